// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio playback path.
// Defines the fetch FSM states, window defaults, direction codes and byte lane selection.
package flash_audio_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT
  } fetch_state_e;

  localparam int unsigned ADDR_W = 23;
  localparam logic [22:0] START_ADDR = 23'h00000;
  localparam logic [22:0] END_ADDR = 23'h7FFFF;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [7:0] SILENT_SAMPLE = 8'h80;

  // Forward words play their low byte first; reverse words play their high byte first.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic order);
    logic [1:0] lane;
    lane = (order == DIR_UP) ? idx : 2'd3 - idx;
    return word[lane*8+:8];
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Two-entry word buffer (current plus prefetch) that serialises each word into four bytes.
// Each word carries the direction it was fetched with, so later direction changes leave buffered words alone.
module word_serializer
  import flash_audio_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        emit,
  input  logic        land,
  input  logic        land_up,
  input  logic [31:0] land_data,
  output logic        cur_valid,
  output logic        next_valid,
  output logic [7:0]  sample
);

  logic [31:0] cur_word_q, cur_word_d;
  logic [31:0] next_word_q, next_word_d;
  logic        cur_valid_q, cur_valid_d;
  logic        next_valid_q, next_valid_d;
  logic        cur_up_q, cur_up_d;
  logic        next_up_q, next_up_d;
  logic [1:0]  idx_q, idx_d;

  assign cur_valid  = cur_valid_q;
  assign next_valid = next_valid_q;
  assign sample     = pick_byte(cur_word_q, idx_q, cur_up_q);

  // A returning word lands in cur whenever cur is empty after this cycle's consumption, so there is no gap.
  always_comb begin
    cur_word_d   = cur_word_q;
    next_word_d  = next_word_q;
    cur_valid_d  = cur_valid_q;
    next_valid_d = next_valid_q;
    cur_up_d     = cur_up_q;
    next_up_d    = next_up_q;
    idx_d        = idx_q;

    if (emit && cur_valid_q) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        cur_word_d   = next_word_q;
        cur_up_d     = next_up_q;
        cur_valid_d  = next_valid_q;
        next_valid_d = 1'b0;
      end
    end

    if (land) begin
      if (!cur_valid_d) begin
        cur_word_d  = land_data;
        cur_up_d    = land_up;
        cur_valid_d = 1'b1;
      end else begin
        next_word_d  = land_data;
        next_up_d    = land_up;
        next_valid_d = 1'b1;
      end
    end

    if (flush) begin
      cur_valid_d  = 1'b0;
      next_valid_d = 1'b0;
      idx_d        = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_word_q   <= '0;
      next_word_q  <= '0;
      cur_valid_q  <= 1'b0;
      next_valid_q <= 1'b0;
      cur_up_q     <= DIR_UP;
      next_up_q    <= DIR_UP;
      idx_q        <= 2'd0;
    end else begin
      cur_word_q   <= cur_word_d;
      next_word_q  <= next_word_d;
      cur_valid_q  <= cur_valid_d;
      next_valid_q <= next_valid_d;
      cur_up_q     <= cur_up_d;
      next_up_q    <= next_up_d;
      idx_q        <= idx_d;
    end
  end

endmodule

// File: rtl/flash_playback_ctrl.sv
// Flash audio playback controller: fetches 32-bit words over an Avalon-style read master
// and plays them as 8-bit samples on sample_tick, with window wrap, direction, pause, silence and restart.
module flash_playback_ctrl
  import flash_audio_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 23,
  parameter logic [ADDR_W-1:0] START_ADDR    = 23'h00000,
  parameter logic [ADDR_W-1:0] END_ADDR      = 23'h7FFFF,
  parameter logic [7:0]        SILENT_SAMPLE = 8'h80
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  input  logic              silent,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [7:0]        audio_out,
  output logic              audio_valid,
  output logic              underrun
);

  fetch_state_e      state_q, state_d;
  logic              flash_read_q, flash_read_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_up_q, req_up_d;
  logic              drop_q, drop_d;
  logic [7:0]        audio_out_q, audio_out_d;
  logic              audio_valid_q, audio_valid_d;
  logic              underrun_q, underrun_d;

  logic              tick_live;
  logic              emit;
  logic              accept;
  logic              land;
  logic              cur_valid;
  logic              next_valid;
  logic [7:0]        sample;
  logic [ADDR_W-1:0] adv_addr;

  assign flash_read    = flash_read_q;
  assign flash_address = req_addr_q;
  assign audio_out     = audio_out_q;
  assign audio_valid   = audio_valid_q;
  assign underrun      = underrun_q;

  assign tick_live = sample_tick && play && !restart;
  assign emit      = tick_live && !silent && cur_valid;
  assign accept    = (state_q == F_REQ) && !flash_waitrequest;
  assign land      = (state_q == F_WAIT) && flash_readdatavalid && !drop_q && !restart;

  word_serializer u_serializer (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (restart),
    .emit       (emit),
    .land       (land),
    .land_up    (req_up_q),
    .land_data  (flash_readdata),
    .cur_valid  (cur_valid),
    .next_valid (next_valid),
    .sample     (sample)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:  if (play && !next_valid && !restart) state_d = F_REQ;
      F_REQ:   if (accept) state_d = F_WAIT;
      F_WAIT:  if (flash_readdatavalid) state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    if (dir == DIR_UP) begin
      adv_addr = (req_addr_q == END_ADDR) ? START_ADDR : req_addr_q + ADDR_W'(1);
    end else begin
      adv_addr = (req_addr_q == START_ADDR) ? END_ADDR : req_addr_q - ADDR_W'(1);
    end
  end

  // A request already in flight at restart must still complete on the bus; drop marks its data for discard.
  always_comb begin
    flash_read_d = (state_d == F_REQ);
    fetch_addr_d = fetch_addr_q;
    req_addr_d   = req_addr_q;
    req_up_d     = req_up_q;
    drop_d       = drop_q;

    if ((state_q == F_IDLE) && (state_d == F_REQ)) req_addr_d = fetch_addr_q;

    if (accept) begin
      req_up_d = dir;
      if (!drop_q && !restart) fetch_addr_d = adv_addr;
    end

    if ((state_q == F_WAIT) && flash_readdatavalid) drop_d = 1'b0;

    if (restart) begin
      fetch_addr_d = (dir == DIR_UP) ? START_ADDR : END_ADDR;
      if ((state_q == F_REQ) || ((state_q == F_WAIT) && !flash_readdatavalid)) drop_d = 1'b1;
    end
  end

  always_comb begin
    audio_out_d   = audio_out_q;
    audio_valid_d = 1'b0;
    underrun_d    = underrun_q;

    if (tick_live) begin
      audio_valid_d = 1'b1;
      if (silent) begin
        audio_out_d = SILENT_SAMPLE;
      end else if (cur_valid) begin
        audio_out_d = sample;
      end else begin
        audio_out_d = 8'h00;
        underrun_d  = 1'b1;
      end
    end

    if (restart) underrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= F_IDLE;
      flash_read_q  <= 1'b0;
      fetch_addr_q  <= START_ADDR;
      req_addr_q    <= START_ADDR;
      req_up_q      <= DIR_UP;
      drop_q        <= 1'b0;
      audio_out_q   <= 8'h00;
      audio_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      flash_read_q  <= flash_read_d;
      fetch_addr_q  <= fetch_addr_d;
      req_addr_q    <= req_addr_d;
      req_up_q      <= req_up_d;
      drop_q        <= drop_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule
